// File: rtl/ddr_deserializer.sv
// DDR serial-to-parallel converter: one bit per clock edge, WIDTH-bit words out on valid/ready.
// Optional saturating overflow counter on port ovf_cnt when DDR_DESER_OVF_CNT_EN is defined.
module ddr_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d,
  input  logic             en,
  input  logic             sync,
  output logic [WIDTH-1:0] data_out,
  output logic             valid,
  input  logic             ready,
  output logic             ovf
`ifdef DDR_DESER_OVF_CNT_EN
  ,
  output logic [CNT_W-1:0] ovf_cnt
`endif
);

  localparam int PAIRS = WIDTH / 2;
  localparam int PC_W  = (PAIRS > 1) ? $clog2(PAIRS) : 1;
  localparam int SR_W  = (WIDTH > 2) ? WIDTH - 2 : 1;
  localparam logic [PC_W-1:0] LAST_PAIR = PC_W'(PAIRS - 1);

  logic             r_s_q;
  logic             f_s_q;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [SR_W-1:0]  sr_q, sr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] word;
  logic [SR_W-1:0]  sr_shift;
  logic             done;

  // Edge capture: r_s_q holds the bit from the last posedge, f_s_q the bit from the last negedge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_s_q <= 1'b0;
    else      r_s_q <= d;
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) f_s_q <= 1'b0;
    else      f_s_q <= d;
  end

  // The first bit of every pair is r_s_q, so it always lands ahead of f_s_q in word order.
  generate
    if (WIDTH == 2) begin : g_w2
      assign word     = MSB_FIRST ? {r_s_q, f_s_q} : {f_s_q, r_s_q};
      assign sr_shift = '0;
    end else if (WIDTH == 4) begin : g_w4
      assign word     = MSB_FIRST ? {sr_q, r_s_q, f_s_q} : {f_s_q, r_s_q, sr_q};
      assign sr_shift = MSB_FIRST ? {r_s_q, f_s_q} : {f_s_q, r_s_q};
    end else begin : g_wn
      assign word     = MSB_FIRST ? {sr_q, r_s_q, f_s_q} : {f_s_q, r_s_q, sr_q};
      assign sr_shift = MSB_FIRST ? {sr_q[SR_W-3:0], r_s_q, f_s_q}
                                  : {f_s_q, r_s_q, sr_q[SR_W-1:2]};
    end
  endgenerate

  // Handshake: valid stays high until a posedge with ready=1; a word completing at that
  // same posedge replaces it and keeps valid high. Completing while valid=1 and ready=0
  // overwrites data_out and raises ovf for exactly one cycle. ready with valid=0 is ignored.
  always_comb begin
    pc_d    = pc_q;
    sr_d    = sr_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovf_d   = 1'b0;
    done    = 1'b0;
    if (sync) begin
      pc_d = '0;
      sr_d = '0;
    end else if (en) begin
      if (pc_q == LAST_PAIR) begin
        pc_d = '0;
        sr_d = '0;
        done = 1'b1;
      end else begin
        pc_d = pc_q + 1'b1;
        sr_d = sr_shift;
      end
    end
    if (done) begin
      data_d  = word;
      valid_d = 1'b1;
      ovf_d   = valid_q && !ready;
    end else if (valid_q && ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= '0;
      sr_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign data_out = data_q;
  assign valid    = valid_q;
  assign ovf      = ovf_q;

`ifdef DDR_DESER_OVF_CNT_EN
  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

  always_comb begin
    ovf_cnt_d = ovf_cnt_q;
    if (ovf_d && (ovf_cnt_q != {CNT_W{1'b1}})) ovf_cnt_d = ovf_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ovf_cnt_q <= '0;
    else      ovf_cnt_q <= ovf_cnt_d;
  end

  assign ovf_cnt = ovf_cnt_q;
`endif

endmodule

// File: tb/tb_ddr_deserializer.sv
// Bench for ddr_deserializer: table vectors, hand sequences for overflow/reset/sync,
// and randomized traffic against a bit-queue reference model.
module tb_ddr_deserializer;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       d = 1'b0;
  logic       en = 1'b0;
  logic       sync = 1'b0;
  logic       ready = 1'b0;
  logic [7:0] data_msb, data_lsb;
  logic       valid_m, valid_l, ovf_m, ovf_l;

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
`ifdef DDR_DESER_OVF_CNT_EN
  logic [7:0] cnt8, cnt_l;
  logic [1:0] cnt2;
  logic [7:0] data_c2;
  logic       valid_c2, ovf_c2;
`endif

  ddr_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1), .CNT_W(8)) u_msb (
    .clk(clk), .rst(rst), .d(d), .en(en), .sync(sync),
    .data_out(data_msb), .valid(valid_m), .ready(ready), .ovf(ovf_m)
`ifdef DDR_DESER_OVF_CNT_EN
    , .ovf_cnt(cnt8)
`endif
  );

  ddr_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0), .CNT_W(8)) u_lsb (
    .clk(clk), .rst(rst), .d(d), .en(en), .sync(sync),
    .data_out(data_lsb), .valid(valid_l), .ready(ready), .ovf(ovf_l)
`ifdef DDR_DESER_OVF_CNT_EN
    , .ovf_cnt(cnt_l)
`endif
  );

`ifdef DDR_DESER_OVF_CNT_EN
  ddr_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1), .CNT_W(2)) u_cnt2 (
    .clk(clk), .rst(rst), .d(d), .en(en), .sync(sync),
    .data_out(data_c2), .valid(valid_c2), .ready(ready), .ovf(ovf_c2),
    .ovf_cnt(cnt2)
  );
`endif

  // ---------------- scoreboard / reference model ----------------
  logic       bit_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] m_msb, m_lsb;
  logic       m_valid, m_ovf;
  int         m_cnt8, m_cnt2;
  logic       p_r, p_f, p_en, p_sy, p_rdy;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_reset();
    bit_q.delete();
    exp_q.delete();
    m_msb = '0; m_lsb = '0; m_valid = 1'b0; m_ovf = 1'b0;
    m_cnt8 = 0; m_cnt2 = 0;
    p_r = 1'b0; p_f = 1'b0; p_en = 1'b0; p_sy = 1'b0; p_rdy = 1'b0;
  endtask

  // Words are formed from the ordered list of received bits since the last alignment point.
  task automatic model_step();
    logic done;
    done  = 1'b0;
    m_ovf = 1'b0;
    if (p_sy) begin
      bit_q.delete();
    end else if (p_en) begin
      bit_q.push_back(p_r);
      bit_q.push_back(p_f);
      if (bit_q.size() == 8) begin
        for (int i = 0; i < 8; i++) begin
          m_msb[7-i] = bit_q[i];
          m_lsb[i]   = bit_q[i];
        end
        bit_q.delete();
        done = 1'b1;
      end
    end
    if (done) begin
      if (m_valid && !p_rdy) begin
        m_ovf = 1'b1;
        if (exp_q.size() > 0) void'(exp_q.pop_back());
        if (m_cnt8 < 255) m_cnt8++;
        if (m_cnt2 < 3) m_cnt2++;
      end else if (m_valid && p_rdy && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
      end
      exp_q.push_back(m_msb);
      m_valid = 1'b1;
    end else if (m_valid && p_rdy) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      m_valid = 1'b0;
    end
  endtask

  task automatic compare_model();
    check("model_valid", valid_m, m_valid);
    check("model_ovf", ovf_m, m_ovf);
    check("model_data_msb", data_msb, m_msb);
    check("model_data_lsb", data_lsb, m_lsb);
    if (m_valid && exp_q.size() > 0) check("model_exp_q", data_msb, exp_q[$]);
`ifdef DDR_DESER_OVF_CNT_EN
    check("model_cnt8", cnt8, m_cnt8);
    check("model_cnt2", cnt2, m_cnt2);
`endif
  endtask

  // ---------------- driver ----------------
  // Entered 2 ns before a posedge. Drives the rising-edge bit, lets the posedge consume the
  // previous pair, checks against the model, then drives the falling-edge bit and controls
  // that the following posedge will use together with this pair.
  task automatic tick(input logic pr, input logic pf, input logic e, input logic sy,
                      input logic rdy);
    d = pr;
    @(posedge clk);
    #1;
    model_step();
    compare_model();
    #1;
    d = pf; en = e; sync = sy; ready = rdy;
    p_r = pr; p_f = pf; p_en = e; p_sy = sy; p_rdy = rdy;
    @(negedge clk);
    #3;
  endtask

  task automatic send_word(input logic [7:0] w, input logic rdy);
    for (int i = 0; i < 4; i++) tick(w[7-2*i], w[6-2*i], 1'b1, 1'b0, rdy);
  endtask

  task automatic do_reset();
    rst = 1'b0; en = 1'b0; sync = 1'b0; ready = 1'b0; d = 1'b0;
    #1;
    check("rst_data_msb", data_msb, 8'h00);
    check("rst_data_lsb", data_lsb, 8'h00);
    check("rst_valid", valid_m, 1'b0);
    check("rst_ovf", ovf_m, 1'b0);
`ifdef DDR_DESER_OVF_CNT_EN
    check("rst_cnt8", cnt8, 8'd0);
`endif
    model_reset();
    @(posedge clk);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic       pr, pf, e, sy, rdy;
    logic [7:0] x_msb, x_lsb;
    logic       x_valid;
  } vec_t;

  vec_t vt[19];
  int   ovf_seen;

  initial begin
    model_reset();
    #1;
    check("init_data", data_msb, 8'h00);
    check("init_valid", valid_m, 1'b0);
    check("init_ovf", ovf_m, 1'b0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;

    // Basic word, en gaps, then sync discarding three partial pairs.
    vt[0]  = '{1, 0, 1, 0, 1, 8'h00, 8'h00, 0};
    vt[1]  = '{1, 1, 1, 0, 1, 8'h00, 8'h00, 0};
    vt[2]  = '{0, 0, 1, 0, 1, 8'h00, 8'h00, 0};
    vt[3]  = '{1, 0, 1, 0, 1, 8'hB2, 8'h4D, 1};
    vt[4]  = '{1, 0, 1, 0, 1, 8'hB2, 8'h4D, 0};
    vt[5]  = '{1, 1, 1, 0, 1, 8'hB2, 8'h4D, 0};
    vt[6]  = '{0, 1, 0, 0, 1, 8'hB2, 8'h4D, 0};
    vt[7]  = '{1, 1, 0, 0, 1, 8'hB2, 8'h4D, 0};
    vt[8]  = '{1, 0, 0, 0, 1, 8'hB2, 8'h4D, 0};
    vt[9]  = '{0, 0, 1, 0, 1, 8'hB2, 8'h4D, 0};
    vt[10] = '{1, 0, 1, 0, 1, 8'hB2, 8'h4D, 1};
    vt[11] = '{0, 1, 1, 0, 1, 8'hB2, 8'h4D, 0};
    vt[12] = '{0, 1, 1, 0, 1, 8'hB2, 8'h4D, 0};
    vt[13] = '{0, 1, 1, 0, 1, 8'hB2, 8'h4D, 0};
    vt[14] = '{1, 1, 1, 1, 1, 8'hB2, 8'h4D, 0};
    vt[15] = '{0, 1, 1, 0, 1, 8'hB2, 8'h4D, 0};
    vt[16] = '{1, 1, 1, 0, 1, 8'hB2, 8'h4D, 0};
    vt[17] = '{0, 0, 1, 0, 1, 8'hB2, 8'h4D, 0};
    vt[18] = '{1, 1, 1, 0, 1, 8'h73, 8'hCE, 1};

    for (int i = 0; i <= 19; i++) begin
      if (i < 19) tick(vt[i].pr, vt[i].pf, vt[i].e, vt[i].sy, vt[i].rdy);
      else        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      if (i > 0) begin
        check($sformatf("vec%0d_msb", i-1), data_msb, vt[i-1].x_msb);
        check($sformatf("vec%0d_lsb", i-1), data_lsb, vt[i-1].x_lsb);
        check($sformatf("vec%0d_valid", i-1), valid_m, vt[i-1].x_valid);
        check($sformatf("vec%0d_ovf", i-1), ovf_m, 1'b0);
      end
    end

    // Three words with ready held low: two overflows, last word kept.
    do_reset();
    ovf_seen = 0;
    send_word(8'h12, 1'b0); ovf_seen += int'(ovf_m);
    for (int i = 0; i < 4; i++) begin
      tick(i == 0 ? 1'b0 : (i == 1 ? 1'b1 : (i == 2 ? 1'b0 : 1'b0)),
           i == 0 ? 1'b0 : (i == 1 ? 1'b1 : (i == 2 ? 1'b1 : 1'b0)), 1'b1, 1'b0, 1'b0);
      ovf_seen += int'(ovf_m);
    end
    for (int i = 0; i < 4; i++) begin
      tick(i == 3 ? 1'b1 : 1'b0, i == 3 ? 1'b0 : 1'b1, 1'b1, 1'b0, 1'b0);
      ovf_seen += int'(ovf_m);
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    ovf_seen += int'(ovf_m);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    ovf_seen += int'(ovf_m);
    check("ovf3_pulses", ovf_seen, 2);
    check("ovf3_data", data_msb, 8'h56);
    check("ovf3_valid", valid_m, 1'b1);
`ifdef DDR_DESER_OVF_CNT_EN
    check("ovf3_cnt8", cnt8, 8'd2);
`endif

    // Reset mid-word while valid is high, then a clean word.
    tick(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    check("pre_rst_valid", valid_m, 1'b1);
    do_reset();
    send_word(8'hC3, 1'b1);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("post_rst_data", data_msb, 8'hC3);
    check("post_rst_valid", valid_m, 1'b1);

`ifdef DDR_DESER_OVF_CNT_EN
    // Five overflows saturate a 2-bit counter at 3.
    do_reset();
    for (int i = 0; i < 6; i++) send_word(8'(8'h11 * (i + 1)), 1'b0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("sat_cnt2", cnt2, 2'd3);
    check("sat_cnt8", cnt8, 8'd5);
`endif

    // Randomized traffic against the model, with one reset in the middle.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if (i == 200) do_reset();
      tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           $urandom_range(0, 9) < 8, $urandom_range(0, 19) == 0,
           1'($urandom_range(0, 1)));
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
